wm8731_config_seq: RTL and testbench
====================================

WM8731_CONFIG_SEQ -- requirements
Module: wm8731_config_seq

Interface
REQ-001 SHALL have parameter CLK_DIV, default 125; system clocks per quarter SCL bit period (50 MHz / (4*125) = 100 kHz SCL).
REQ-002 SHALL have parameter DEV_ADDR, default 7'h1A; 7-bit codec I2C address.
REQ-003 SHALL have parameter MAX_RETRY, default 3; number of retries per word after a NACK.
REQ-004 SHALL have parameter AUTO_START, default 1; when 1, the sequence starts once after reset release.
REQ-005 clk  input  1  system clock, single clock domain; all logic on the rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle pulse; (re)runs the full configuration sequence.
REQ-008 busy  output  1  high while a sequence is in progress.
REQ-009 done  output  1  high after a sequence completes with every word ACKed; cleared by the next start.
REQ-010 ack_error  output  1  high after a word exhausts its retries; cleared by the next start.
REQ-011 err_index  output  4  ROM index of the failing word, valid while ack_error is high.
REQ-012 i2c_sclk  output  1  I2C clock, driven push-pull.
REQ-013 i2c_sdat  inout  1  I2C data, open-drain: driven 0 or released to Z, never driven 1.

Function
REQ-014 SHALL hold an 11-entry ROM of 16-bit words {reg[6:0], data[8:0]}, in order: R15=000, R0=017, R1=017, R2=079, R3=079, R4=012, R5=000, R6=000, R7=002, R8=000, R9=001 (data in hex).
REQ-015 SHALL generate a tick every CLK_DIV clocks; each SCL bit SHALL take 4 ticks. Phase 0: SCL low, SDA updated. Phases 1-2: SCL high. Phase 3: SCL low. SDA SHALL be sampled at the end of phase 2.
REQ-016 SHALL have states IDLE, START, ADDR, ACK0, HI, ACK1, LO, ACK2, STOP, GAP, FIN, ERR.
REQ-017 IDLE->START on start, or on the first cycle after reset release when AUTO_START=1. The ROM index SHALL clear to 0, and done and ack_error SHALL clear.
REQ-018 START SHALL take 4 ticks: SDA released with SCL high, then SDA low while SCL is high, then SCL low.
REQ-019 ADDR, HI and LO SHALL each shift out 8 bits MSB first: ADDR = {DEV_ADDR, 1'b0}, HI = word[15:8], LO = word[7:0].
REQ-020 ACKn SHALL release SDA for one bit; a sampled 0 is an ACK and advances the state, a sampled 1 is a NACK and goes to STOP with the retry flag set.
REQ-021 STOP SHALL take 4 ticks: SDA low, SCL high, then SDA released while SCL is high.
REQ-022 GAP SHALL hold the bus idle (SCL=1, SDA=Z) for 8 ticks.
REQ-023 After GAP, with no retry flag: index+1. If index+1 == 11, go to FIN; otherwise go to START, with the retry count reset to 0.
REQ-024 After GAP, with the retry flag set: if the retry count < MAX_RETRY, increment it and resend the same word from START; otherwise go to ERR and latch err_index = index.
REQ-025 FIN SHALL set done=1 and busy=0 and return to IDLE. ERR SHALL set ack_error=1 and busy=0 and return to IDLE.
REQ-026 start while busy=1 SHALL be ignored.
REQ-027 busy SHALL rise on the clock edge that accepts start and SHALL fall on the same edge that done or ack_error rises.
REQ-028 One full word transaction SHALL be 4+36*3+4+8 = 124 ticks.
REQ-029 The bus SHALL be idle (SCL=1, SDA=Z) in IDLE, FIN and ERR.

Reset
REQ-030 reset_n low SHALL asynchronously force: state=IDLE, index=0, retry count=0, tick counter=0, busy=0, done=0, ack_error=0, err_index=0, i2c_sclk=1, i2c_sdat=Z.
REQ-031 Reset asserted mid-transaction SHALL abort immediately with no STOP generated. When AUTO_START=1, the sequence SHALL restart from index 0 after release.

Verification
REQ-032 Setup: AUTO_START=1, CLK_DIV=4, slave model ACKs all bytes -> 11 transactions; bytes per word are 0x34, {reg,d8}, d[7:0] (e.g. word 0 = 34 1E 00, word 10 = 34 12 01); done=1 after 11*124*4 clocks plus pipeline slack.
REQ-033 Setup: slave NACKs the address byte of word 3 once -> STOP, GAP, then word 3 resent identically; sequence completes with done=1 and ack_error=0.
REQ-034 Setup: slave always NACKs the LO byte of word 5, MAX_RETRY=3 -> word 5 is sent 4 times; ack_error=1, err_index=5, done=0, busy=0.
REQ-035 Setup: start pulsed while busy, then again after done -> the first pulse has no effect; the second pulse clears done and reruns the sequence from index 0.
REQ-036 Setup: reset_n pulled low during the HI byte of word 2 -> next cycle SCL=1, SDA=Z, busy=0; after release the sequence restarts at word 0.
REQ-037 Checker: SDA never changes while SCL=1 except during START/STOP; the SDA driver is never 1.

Source files
------------

// File: rtl/wm8731_config_seq.sv
// WM8731 configuration sequencer: an I2C write master that streams an 11-word register
// table to the codec after reset or on request, retrying each word after a NACK.
module wm8731_config_seq #(
  parameter int unsigned CLK_DIV    = 125,
  parameter logic [6:0]  DEV_ADDR   = 7'h1A,
  parameter int unsigned MAX_RETRY  = 3,
  parameter int unsigned AUTO_START = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       ack_error,
  output logic [3:0] err_index,
  output logic       i2c_sclk,
  inout  wire        i2c_sdat
);

  localparam int unsigned   TW         = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(CLK_DIV - 1);
  localparam logic [3:0]    LAST_INDEX = 4'd10;
  localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRY);

  typedef enum logic [3:0] {
    IDLE, START, ADDR, ACK0, HI, ACK1, LO, ACK2, STOP, GAP, FIN, ERR
  } state_t;

  // Register table, {reg[6:0], data[8:0]} in the order the codec expects.
  function automatic logic [15:0] rom_word(input logic [3:0] idx);
    logic [15:0] w;
    case (idx)
      4'd0:    w = {7'd15, 9'h000};
      4'd1:    w = {7'd0,  9'h017};
      4'd2:    w = {7'd1,  9'h017};
      4'd3:    w = {7'd2,  9'h079};
      4'd4:    w = {7'd3,  9'h079};
      4'd5:    w = {7'd4,  9'h012};
      4'd6:    w = {7'd5,  9'h000};
      4'd7:    w = {7'd6,  9'h000};
      4'd8:    w = {7'd7,  9'h002};
      4'd9:    w = {7'd8,  9'h000};
      4'd10:   w = {7'd9,  9'h001};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  state_t          state_r, state_nx_s;
  logic [TW-1:0]   tick_cnt_r;
  logic [1:0]      phase_r;
  logic [2:0]      bit_r;
  logic [3:0]      index_r, retry_r, err_index_r;
  logic            retry_flag_r, nack_r, first_r;
  logic            busy_r, done_r, ack_error_r, sclk_r, sda_low_r;
  logic            tick_s, bit_done_s, running_s, is_ack_s, gap_exit_s, accept_s, mid_s;
  logic            sclk_nx_s, sda_low_nx_s, bit_val_s;
  logic [7:0]      byte_s;
  logic [15:0]     word_s;

  assign running_s  = !((state_r == IDLE) || (state_r == FIN) || (state_r == ERR));
  assign tick_s     = running_s && (tick_cnt_r == TICK_LAST);
  assign bit_done_s = tick_s && (phase_r == 2'd3);
  assign is_ack_s   = (state_r == ACK0) || (state_r == ACK1) || (state_r == ACK2);
  assign gap_exit_s = (state_r == GAP) && bit_done_s && (bit_r == 3'd1);
  assign mid_s      = phase_r[0] ^ phase_r[1];
  assign word_s     = rom_word(index_r);

  // Next-state decode; every bus state ends on the last phase of a bit.
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (start || ((AUTO_START != 0) && first_r)) begin
          state_nx_s = START;
          accept_s   = 1'b1;
        end else begin
          state_nx_s = IDLE;
        end
      end
      START: state_nx_s = bit_done_s ? ADDR : START;
      ADDR:  state_nx_s = (bit_done_s && (bit_r == 3'd7)) ? ACK0 : ADDR;
      ACK0:  state_nx_s = !bit_done_s ? ACK0 : (nack_r ? STOP : HI);
      HI:    state_nx_s = (bit_done_s && (bit_r == 3'd7)) ? ACK1 : HI;
      ACK1:  state_nx_s = !bit_done_s ? ACK1 : (nack_r ? STOP : LO);
      LO:    state_nx_s = (bit_done_s && (bit_r == 3'd7)) ? ACK2 : LO;
      ACK2:  state_nx_s = bit_done_s ? STOP : ACK2;
      STOP:  state_nx_s = bit_done_s ? GAP : STOP;
      GAP: begin
        if (!gap_exit_s) begin
          state_nx_s = GAP;
        end else if (!retry_flag_r) begin
          state_nx_s = (index_r == LAST_INDEX) ? FIN : START;
        end else begin
          state_nx_s = (retry_r < RETRY_MAX) ? START : ERR;
        end
      end
      FIN:     state_nx_s = IDLE;
      ERR:     state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Bus waveform decode for the current state and quarter-bit phase.
  always_comb begin
    sclk_nx_s    = 1'b1;
    sda_low_nx_s = 1'b0;
    case (state_r)
      ADDR:    byte_s = {DEV_ADDR, 1'b0};
      HI:      byte_s = word_s[15:8];
      LO:      byte_s = word_s[7:0];
      default: byte_s = 8'h00;
    endcase
    bit_val_s = byte_s[3'd7 - bit_r];
    case (state_r)
      START: begin
        sclk_nx_s    = (phase_r != 2'd3);
        sda_low_nx_s = phase_r[1];
      end
      ADDR, HI, LO: begin
        sclk_nx_s    = mid_s;
        sda_low_nx_s = ~bit_val_s;
      end
      ACK0, ACK1, ACK2: begin
        sclk_nx_s    = mid_s;
        sda_low_nx_s = 1'b0;
      end
      STOP: begin
        sclk_nx_s    = (phase_r != 2'd0);
        sda_low_nx_s = ~phase_r[1];
      end
      default: begin
        sclk_nx_s    = 1'b1;
        sda_low_nx_s = 1'b0;
      end
    endcase
  end

  // Tick prescaler, quarter-bit phase and bit-within-state counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt_r <= '0;
      phase_r    <= 2'd0;
      bit_r      <= 3'd0;
    end else if (!running_s) begin
      tick_cnt_r <= '0;
      phase_r    <= 2'd0;
      bit_r      <= 3'd0;
    end else begin
      tick_cnt_r <= tick_s ? '0 : tick_cnt_r + 1'b1;
      phase_r    <= tick_s ? phase_r + 2'd1 : phase_r;
      bit_r      <= (state_nx_s != state_r) ? 3'd0 : (bit_done_s ? bit_r + 3'd1 : bit_r);
    end
  end

  // Sequence state, word index, retry bookkeeping and status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      index_r      <= 4'd0;
      retry_r      <= 4'd0;
      retry_flag_r <= 1'b0;
      nack_r       <= 1'b1;
      first_r      <= 1'b1;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      ack_error_r  <= 1'b0;
      err_index_r  <= 4'd0;
    end else begin
      state_r <= state_nx_s;
      first_r <= 1'b0;
      if (accept_s) begin
        index_r      <= 4'd0;
        retry_r      <= 4'd0;
        retry_flag_r <= 1'b0;
        busy_r       <= 1'b1;
        done_r       <= 1'b0;
        ack_error_r  <= 1'b0;
      end
      // Slave answer is sampled at the end of the second SCL-high phase.
      if (is_ack_s && tick_s && (phase_r == 2'd2)) nack_r <= i2c_sdat;
      if (is_ack_s && bit_done_s && nack_r) retry_flag_r <= 1'b1;
      if (gap_exit_s) begin
        retry_flag_r <= 1'b0;
        if (!retry_flag_r) begin
          index_r <= index_r + 4'd1;
          retry_r <= 4'd0;
        end else if (retry_r < RETRY_MAX) begin
          retry_r <= retry_r + 4'd1;
        end else begin
          err_index_r <= index_r;
        end
      end
      if (state_r == FIN) begin
        done_r <= 1'b1;
        busy_r <= 1'b0;
      end
      if (state_r == ERR) begin
        ack_error_r <= 1'b1;
        busy_r      <= 1'b0;
      end
    end
  end

  // Registered bus drivers; reset leaves the bus idle with no STOP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_r    <= 1'b1;
      sda_low_r <= 1'b0;
    end else begin
      sclk_r    <= sclk_nx_s;
      sda_low_r <= sda_low_nx_s;
    end
  end

  assign i2c_sclk  = sclk_r;
  assign i2c_sdat  = sda_low_r ? 1'b0 : 1'bz;
  assign busy      = busy_r;
  assign done      = done_r;
  assign ack_error = ack_error_r;
  assign err_index = err_index_r;

endmodule

// File: tb/tb_wm8731_config_seq.sv
// Bench for wm8731_config_seq: an I2C slave model with scripted NACKs records the bus,
// and a table-driven model predicts the byte stream, transaction count and final status.
module tb_wm8731_config_seq;

  localparam int CLK_DIV   = 4;
  localparam int MAX_RETRY = 3;
  localparam int LIMIT     = 20000;
  localparam int REG_TAB [0:10] = '{15, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
  localparam int DAT_TAB [0:10] = '{'h000, 'h017, 'h017, 'h079, 'h079, 'h012,
                                    'h000, 'h000, 'h002, 'h000, 'h001};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       busy, done, ack_error, i2c_sclk;
  logic [3:0] err_index;
  logic       slave_low = 1'b0;
  wire        i2c_sdat;

  pullup (i2c_sdat);
  assign i2c_sdat = slave_low ? 1'b0 : 1'bz;

  wm8731_config_seq #(
    .CLK_DIV(CLK_DIV), .DEV_ADDR(7'h1A), .MAX_RETRY(MAX_RETRY), .AUTO_START(1)
  ) dut (
    .clk(clk), .reset_n(rst_n), .start(start), .busy(busy), .done(done),
    .ack_error(ack_error), .err_index(err_index), .i2c_sclk(i2c_sclk), .i2c_sdat(i2c_sdat)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave configuration (written by the stimulus only) and monitor state.
  int cfg_nw = -1, cfg_np = 0, cfg_nn = 0, ok_base = 0, nack_base = 0;
  logic       prev_scl = 1'b1, prev_sda = 1'b1, ack_ph = 1'b0;
  logic [7:0] shreg = 8'h00;
  int         bitcnt = 0, byte_pos = 0, ok_cnt = 0, nack_used = 0, stop_cnt = 0, proto_err = 0;
  logic [7:0] byte_q [$];
  logic       sda_v, nack_now;

  assign sda_v    = i2c_sdat;
  assign nack_now = ((ok_cnt - ok_base) == cfg_nw) && (byte_pos == cfg_np) &&
                    ((nack_used - nack_base) < cfg_nn);

  // Bus monitor and slave: collects bytes, answers ACK/NACK, flags SDA edges inside a byte.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_scl  <= 1'b1;
      prev_sda  <= 1'b1;
      bitcnt    <= 0;
      byte_pos  <= 0;
      ack_ph    <= 1'b0;
      slave_low <= 1'b0;
    end else begin
      prev_scl <= i2c_sclk;
      prev_sda <= sda_v;
      if (i2c_sclk && prev_scl && (sda_v != prev_sda)) begin
        if (ack_ph || bitcnt >= 2) proto_err <= proto_err + 1;
        if (sda_v) stop_cnt <= stop_cnt + 1;
        bitcnt   <= 0;
        byte_pos <= 0;
        ack_ph   <= 1'b0;
      end else if (i2c_sclk && !prev_scl) begin
        if (!ack_ph && bitcnt < 8) begin
          shreg  <= {shreg[6:0], sda_v};
          bitcnt <= bitcnt + 1;
        end
      end else if (!i2c_sclk && prev_scl) begin
        if (ack_ph) begin
          ack_ph    <= 1'b0;
          slave_low <= 1'b0;
          bitcnt    <= 0;
          byte_pos  <= byte_pos + 1;
        end else if (bitcnt == 8) begin
          ack_ph <= 1'b1;
          byte_q.push_back(shreg);
          if (nack_now) begin
            nack_used <= nack_used + 1;
          end else begin
            slave_low <= 1'b1;
            if (byte_pos == 2) ok_cnt <= ok_cnt + 1;
          end
        end
      end
    end
  end

  // Reference model: bytes of one word and the full expected run for a NACK script.
  logic [7:0] exp_q [$];
  int exp_txn, exp_eidx;
  bit exp_err;

  function automatic logic [7:0] word_byte(input int w, input int b);
    int v;
    if (b == 0)      v = 'h1A * 2;
    else if (b == 1) v = REG_TAB[w] * 2 + DAT_TAB[w] / 256;
    else             v = DAT_TAB[w] % 256;
    return v[7:0];
  endfunction

  task automatic build_model(input int nw, input int np, input int nn);
    exp_q.delete();
    exp_txn  = 0;
    exp_err  = 1'b0;
    exp_eidx = 0;
    for (int w = 0; w < 11 && !exp_err; w++) begin
      int fails = (w == nw) ? nn : 0;
      int sends = (fails > MAX_RETRY) ? MAX_RETRY + 1 : fails + 1;
      for (int s = 0; s < sends; s++) begin
        int nbytes = (s < fails) ? np + 1 : 3;
        for (int b = 0; b < nbytes; b++) exp_q.push_back(word_byte(w, b));
        exp_txn++;
      end
      if (fails > MAX_RETRY) begin
        exp_err  = 1'b1;
        exp_eidx = w;
      end
    end
  endtask

  task automatic run_seq(input string tag, input int nw, input int np, input int nn,
                         input bit by_reset, input bit mid_pulse);
    int cyc, base_b, base_t, base_p, got_n, bad0;
    build_model(nw, np, nn);
    base_b = byte_q.size();
    base_t = stop_cnt;
    base_p = proto_err;
    ok_base = ok_cnt;
    nack_base = nack_used;
    cfg_nw = nw;
    cfg_np = np;
    cfg_nn = nn;
    @(negedge clk);
    if (by_reset) rst_n = 1'b1;
    else start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val({tag, ":busy_rise"}, busy, 1'b1);
    check_val({tag, ":done_clr"}, done, 1'b0);
    check_val({tag, ":err_clr"}, ack_error, 1'b0);
    if (mid_pulse) begin
      repeat (600) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 0;
    while (busy && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    check_val({tag, ":in_time"}, (cyc < LIMIT), 1'b1);
    check_val({tag, ":done"}, done, !exp_err);
    check_val({tag, ":ack_error"}, ack_error, exp_err);
    if (exp_err) check_val({tag, ":err_index"}, err_index, exp_eidx);
    check_val({tag, ":scl_idle"}, i2c_sclk, 1'b1);
    check_val({tag, ":sda_idle"}, sda_v, 1'b1);
    check_val({tag, ":txn_count"}, stop_cnt - base_t, exp_txn);
    got_n = byte_q.size() - base_b;
    check_val({tag, ":byte_count"}, got_n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_n; i++) begin
      bad0 = n_bad;
      check_val($sformatf("%s:byte%0d", tag, i), byte_q[base_b + i], exp_q[i]);
      if (n_bad != bad0) break;
    end
    check_val({tag, ":sda_stable"}, proto_err - base_p, 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc;
    #12;
    check_val("rst:busy", busy, 1'b0);
    check_val("rst:done", done, 1'b0);
    check_val("rst:ack_error", ack_error, 1'b0);
    check_val("rst:err_index", err_index, 4'd0);
    check_val("rst:scl", i2c_sclk, 1'b1);
    check_val("rst:sda", sda_v, 1'b1);
    repeat (3) @(negedge clk);

    run_seq("auto", -1, 0, 0, 1'b1, 1'b0);
    run_seq("nack_addr_w3", 3, 0, 1, 1'b0, 1'b0);
    run_seq("nack_lo_w5", 5, 2, MAX_RETRY + 1, 1'b0, 1'b0);
    for (int r = 0; r < 3; r++) begin
      int nw, np, nn;
      nw = $urandom_range(10, 0);
      np = $urandom_range(2, 0);
      nn = $urandom_range(MAX_RETRY + 1, 0);
      run_seq($sformatf("rand%0d_w%0d_b%0d_n%0d", r, nw, np, nn), nw, np, nn, 1'b0, 1'b0);
    end
    run_seq("busy_pulse", -1, 0, 0, 1'b0, 1'b1);

    // Abort during the HI byte of word 2, then expect a clean auto restart.
    ok_base = ok_cnt;
    cfg_nw = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!((ok_cnt - ok_base) == 2 && byte_pos == 1 && bitcnt >= 3) && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    check_val("abort:reached_w2_hi", (cyc < LIMIT), 1'b1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_val("abort:scl", i2c_sclk, 1'b1);
    check_val("abort:sda", sda_v, 1'b1);
    check_val("abort:busy", busy, 1'b0);
    check_val("abort:done", done, 1'b0);
    repeat (3) @(negedge clk);
    run_seq("rst_restart", -1, 0, 0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
